// File: rtl/matmul_pkg.sv
// matmul_pkg
//   Shared types and default sizes for the sigma^T*J*sigma sweep sequencer.
//   sweep_state_e : sequencer FSM states
//   energy_t      : signed energy word at the default ENERGY_WIDTH
//   ENERGY_MAX    : most positive energy_t, the "no best yet" value
//   chunk_idx_t   : chunk index counter, one bit wider than needed so the
//                   count can reach NUM_J_CHUNKS without wrapping
package matmul_pkg;

    localparam int DEF_VECTOR_SIZE  = 256;
    localparam int DEF_NUM_J_CHUNKS = 4;
    localparam int DEF_ENERGY_WIDTH = 21;
    localparam int DEF_ADDR_WIDTH   = 16;
    localparam int DEF_DRAIN_CYCLES = 10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        STREAM,
        DRAIN,
        DONE
    } sweep_state_e;

    typedef logic signed [DEF_ENERGY_WIDTH-1:0] energy_t;

    localparam energy_t ENERGY_MAX = {1'b0, {(DEF_ENERGY_WIDTH-1){1'b1}}};

    typedef logic [$clog2(DEF_NUM_J_CHUNKS):0] chunk_idx_t;

endpackage

// File: rtl/matmul_drain_timer.sv
// matmul_drain_timer
//   Down-counter that times the datapath drain after the last J chunk beat.
//   clk, rst_n : clock, async active-low reset
//   load_i     : load DRAIN_CYCLES (the cycle the sequencer enters DRAIN)
//   run_i      : count down (high while the sequencer sits in DRAIN)
//   expire_o   : high on the final drain cycle; the sequencer leaves DRAIN on it
module matmul_drain_timer #(
    parameter int DRAIN_CYCLES = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int TW = $clog2(DRAIN_CYCLES + 1);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= TW'(DRAIN_CYCLES);
        end else if (run_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Loaded with N, the run lasts exactly N cycles: expire on the count of 1.
    // The <= also gives a one-cycle drain if DRAIN_CYCLES is 0.
    assign expire_o = run_i && (cnt_q <= TW'(1));

endmodule

// File: rtl/matmul_sweep_ctrl.sv
// matmul_sweep_ctrl
//   Sequencer for the sigma^T*J*sigma energy datapath. Takes one spin-vector
//   command, requests NUM_J_CHUNKS J chunks from memory, pulses the datapath
//   start on the first returned beat, waits out the pipeline drain, then
//   reports the energy and tracks the best (lowest) accepted energy.
//   Command side : cmd_valid_i/cmd_ready_o, sigma_i, clear_best_i
//   Memory side  : mem_req_valid_o/mem_req_ready_i, mem_addr_o, mem_rsp_valid_i
//   Datapath     : mm_start_o, mm_sigma_o, energy_i
//   Result       : result_valid_o, result_energy_o, accept_o, best_energy_o
//   Status       : busy_o, err_o (sticky response-protocol error)
//   Optional     : `define MATMUL_SWEEP_PERF_EN adds perf_runs_o and
//                  perf_stall_o saturating counters.
module matmul_sweep_ctrl
    import matmul_pkg::*;
#(
    parameter int VECTOR_SIZE  = DEF_VECTOR_SIZE,
    parameter int NUM_J_CHUNKS = DEF_NUM_J_CHUNKS,
    parameter int ENERGY_WIDTH = DEF_ENERGY_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int J_BASE_ADDR  = 0,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic [VECTOR_SIZE-1:0]         sigma_i,
    input  logic                           clear_best_i,
    output logic                           mem_req_valid_o,
    input  logic                           mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    input  logic                           mem_rsp_valid_i,
    output logic                           mm_start_o,
    output logic [VECTOR_SIZE-1:0]         mm_sigma_o,
    input  logic signed [ENERGY_WIDTH-1:0] energy_i,
    output logic                           result_valid_o,
    output logic signed [ENERGY_WIDTH-1:0] result_energy_o,
    output logic                           accept_o,
    output logic signed [ENERGY_WIDTH-1:0] best_energy_o,
    output logic                           busy_o,
    output logic                           err_o
`ifdef MATMUL_SWEEP_PERF_EN
    ,
    output logic [31:0]                    perf_runs_o,
    output logic [31:0]                    perf_stall_o
`endif
);

    localparam int IW = $clog2(NUM_J_CHUNKS) + 1;
    localparam logic [IW-1:0] N_CHUNKS = IW'(NUM_J_CHUNKS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_J_CHUNKS - 1);
    localparam logic signed [ENERGY_WIDTH-1:0] E_MAX = {1'b0, {(ENERGY_WIDTH-1){1'b1}}};

    sweep_state_e state_q, state_d;

    logic [IW-1:0]                  req_idx_q, rsp_idx_q;
    logic [VECTOR_SIZE-1:0]         sigma_q;
    logic signed [ENERGY_WIDTH-1:0] best_q, energy_q;
    logic                           err_q, err_run_q;

    logic in_burst, cmd_fire, req_fire, last_req;
    logic beat, extra_beat, gap, last_beat, rsp_done;
    logic drain_load, drain_expire, accept;

    // Responses are only meaningful while requests are outstanding; they may
    // start arriving before the last request is accepted.
    assign in_burst   = (state_q == ISSUE) || (state_q == STREAM);
    assign cmd_fire   = cmd_valid_i && (state_q == IDLE);
    assign req_fire   = (state_q == ISSUE) && mem_req_ready_i;
    assign last_req   = req_fire && (req_idx_q == LAST_IDX);
    assign beat       = in_burst && mem_rsp_valid_i && (rsp_idx_q < N_CHUNKS);
    assign extra_beat = mem_rsp_valid_i && !beat;
    // Once the burst has started every cycle must carry a beat until the last.
    assign gap        = in_burst && !mem_rsp_valid_i && (rsp_idx_q != '0) && (rsp_idx_q < N_CHUNKS);
    assign last_beat  = beat && (rsp_idx_q == LAST_IDX);
    assign rsp_done   = (rsp_idx_q == N_CHUNKS) || last_beat;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire)     state_d = ISSUE;
            ISSUE:   if (last_req)     state_d = rsp_done ? DRAIN : STREAM;
            STREAM:  if (last_beat)    state_d = DRAIN;
            DRAIN:   if (drain_expire) state_d = DONE;
            DONE:                      state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    assign drain_load = (state_d == DRAIN) && (state_q != DRAIN);

    matmul_drain_timer #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_drain_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (drain_load),
        .run_i    (state_q == DRAIN),
        .expire_o (drain_expire)
    );

    // A run that saw a response gap still reports its energy but never wins.
    assign accept = (state_q == DONE) && !err_run_q && (energy_i < best_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_idx_q <= '0;
            rsp_idx_q <= '0;
            sigma_q   <= '0;
            best_q    <= E_MAX;
            energy_q  <= '0;
            err_q     <= 1'b0;
            err_run_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (cmd_fire) begin
                sigma_q   <= sigma_i;
                req_idx_q <= '0;
                rsp_idx_q <= '0;
                err_run_q <= 1'b0;
            end else begin
                if (req_fire) req_idx_q <= req_idx_q + 1'b1;
                if (beat)     rsp_idx_q <= rsp_idx_q + 1'b1;
                if (gap)      err_run_q <= 1'b1;
            end

            if (gap || extra_beat) err_q <= 1'b1;

            if (state_q == DONE) energy_q <= energy_i;

            // Clear beats a same-cycle accept.
            if (clear_best_i)  best_q <= E_MAX;
            else if (accept)   best_q <= energy_i;
        end
    end

    assign cmd_ready_o     = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign mem_req_valid_o = (state_q == ISSUE);
    assign mem_addr_o      = ADDR_WIDTH'(J_BASE_ADDR) + ADDR_WIDTH'(req_idx_q);
    assign mm_start_o      = beat && (rsp_idx_q == '0);
    assign mm_sigma_o      = sigma_q;
    assign result_valid_o  = (state_q == DONE);
    // Energy is live on the DONE cycle; the captured copy holds it afterwards.
    assign result_energy_o = (state_q == DONE) ? energy_i : energy_q;
    assign accept_o        = accept;
    assign best_energy_o   = best_q;
    assign err_o           = err_q;

`ifdef MATMUL_SWEEP_PERF_EN
    logic [31:0] perf_runs_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_runs_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if ((state_q == DONE) && (perf_runs_q != '1))
                perf_runs_q <= perf_runs_q + 1'b1;
            if (mem_req_valid_o && !mem_req_ready_i && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    assign perf_runs_o  = perf_runs_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_matmul_sweep_ctrl.sv
// tb_matmul_sweep_ctrl
//   Table of sweep runs with hand-computed expected accept/best/err, a
//   randomized phase checked against a plain best-so-far model, and hand
//   sequences for mid-run reset and a stray response beat while idle.
//   The bench plays the J memory: it accepts requests (with optional stalls)
//   and returns beats either per request after a latency or as one burst.
module tb_matmul_sweep_ctrl;

    localparam int VS    = 256;
    localparam int N     = 4;
    localparam int EW    = 21;
    localparam int AW    = 16;
    localparam int DRAIN = 10;
    localparam logic signed [EW-1:0] EMAX = 21'sd1048575;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cmd_valid_i, cmd_ready_o;
    logic [VS-1:0]        sigma_i;
    logic                 clear_best_i;
    logic                 mem_req_valid_o, mem_req_ready_i;
    logic [AW-1:0]        mem_addr_o;
    logic                 mem_rsp_valid_i;
    logic                 mm_start_o;
    logic [VS-1:0]        mm_sigma_o;
    logic signed [EW-1:0] energy_i;
    logic                 result_valid_o;
    logic signed [EW-1:0] result_energy_o;
    logic                 accept_o;
    logic signed [EW-1:0] best_energy_o;
    logic                 busy_o, err_o;
`ifdef MATMUL_SWEEP_PERF_EN
    logic [31:0]          perf_runs_o, perf_stall_o;
`endif

    matmul_sweep_ctrl #(
        .VECTOR_SIZE(VS), .NUM_J_CHUNKS(N), .ENERGY_WIDTH(EW),
        .ADDR_WIDTH(AW), .J_BASE_ADDR(0), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .sigma_i(sigma_i), .clear_best_i(clear_best_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mm_start_o(mm_start_o), .mm_sigma_o(mm_sigma_o), .energy_i(energy_i),
        .result_valid_o(result_valid_o), .result_energy_o(result_energy_o),
        .accept_o(accept_o), .best_energy_o(best_energy_o),
        .busy_o(busy_o), .err_o(err_o)
`ifdef MATMUL_SWEEP_PERF_EN
        , .perf_runs_o(perf_runs_o), .perf_stall_o(perf_stall_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;          // energy presented by the datapath for this run
        int stall_idx;  // request index held off by mem_req_ready_i
        int stall_len;  // cycles of that hold-off
        int gap_after;  // beat index followed by a one-cycle gap, -1 none
        int lat;        // memory latency in cycles
        bit burst;      // return all beats as one burst after the last request
        bit clr;        // pulse clear_best_i on the DONE cycle
        bit cmd_drain;  // hold cmd_valid_i from last beat through DONE
        bit exp_acc;
        int exp_best;
        bit exp_err;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        cmd_valid_i     = 1'b0;
        clear_best_i    = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        sigma_i  = '0;
        energy_i = '0;
        repeat (2) step();
        @(negedge clk);
        chk("rst cmd_ready", cmd_ready_o, 1);
        chk("rst busy", busy_o, 0);
        chk("rst req_valid", mem_req_valid_o, 0);
        chk("rst result_valid", result_valid_o, 0);
        chk("rst mm_start", mm_start_o, 0);
        chk("rst err", err_o, 0);
        chk("rst best", best_energy_o, EMAX);
        chk("rst sigma zero", (mm_sigma_o == '0), 1);
        step();
        rst_n = 1'b1;
    endtask

    task automatic do_run(input string nm, input vec_t v);
        logic [VS-1:0] sig;
        int h, req_cnt, beat_cnt, stall_ctr, start_cnt, start_cyc;
        int first_beat, last_beat, res_cnt, res_cyc;
        int bad_addr, bad_sig, bad_cmd;
        logic signed [EW-1:0] got_e;
        logic got_acc;
        bit gapped, done;
        int due[$];

        for (int i = 0; i < VS / 32; i++) sig[i*32 +: 32] = $urandom;
        req_cnt = 0; beat_cnt = 0; stall_ctr = 0; start_cnt = 0; start_cyc = -1;
        first_beat = -1; last_beat = -1; res_cnt = 0; res_cyc = -1;
        bad_addr = 0; bad_sig = 0; bad_cmd = 0; got_e = '0; got_acc = 1'b0;
        gapped = 0; done = 0;

        step();
        sigma_i     = sig;
        energy_i    = EW'(v.e);
        cmd_valid_i = 1'b1;
        @(negedge clk);
        chk({nm, " cmd_ready"}, cmd_ready_o, 1);
        h = cyc;

        for (int t = 0; t < 300 && !done; t++) begin
            step();
            cmd_valid_i     = v.cmd_drain && (beat_cnt == N) && (res_cnt == 0);
            mem_req_ready_i = !(req_cnt == v.stall_idx && stall_ctr < v.stall_len);
            clear_best_i    = v.clr && (last_beat >= 0) && (cyc == last_beat + DRAIN + 1);
            mem_rsp_valid_i = 1'b0;
            if (v.gap_after >= 0 && !gapped && beat_cnt == v.gap_after + 1) begin
                gapped = 1;
                foreach (due[i]) due[i]++;
            end
            if (due.size() > 0 && due[0] <= cyc) begin
                void'(due.pop_front());
                mem_rsp_valid_i = 1'b1;
            end

            @(negedge clk);
            if (busy_o && mm_sigma_o !== sig) bad_sig++;
            if (cmd_valid_i && cmd_ready_o) bad_cmd++;
            if (mem_req_valid_o) begin
                if (mem_addr_o !== AW'(req_cnt)) bad_addr++;
                if (mem_req_ready_i) begin
                    req_cnt++;
                    if (!v.burst) due.push_back(cyc + v.lat);
                    else if (req_cnt == N)
                        for (int k = 0; k < N; k++) due.push_back(cyc + v.lat + k);
                end else begin
                    stall_ctr++;
                end
            end
            if (mm_start_o) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (mem_rsp_valid_i) begin
                if (beat_cnt == 0) first_beat = cyc;
                beat_cnt++;
                if (beat_cnt == N) last_beat = cyc;
            end
            if (result_valid_o) begin
                res_cnt++;
                res_cyc = cyc;
                got_e   = result_energy_o;
                got_acc = accept_o;
            end
            if (res_cnt > 0 && cyc > res_cyc) done = 1;
        end
        idle_inputs();

        chk({nm, " result pulse count"}, res_cnt, 1);
        chk({nm, " req count"}, req_cnt, N);
        chk({nm, " addr sequence"}, bad_addr, 0);
        chk({nm, " sigma held"}, bad_sig, 0);
        chk({nm, " cmd ignored while busy"}, bad_cmd, 0);
        chk({nm, " start count"}, start_cnt, 1);
        chk({nm, " start on beat0"}, start_cyc, first_beat);
        chk({nm, " last beat to result"}, res_cyc - last_beat, DRAIN + 1);
        if (v.stall_len == 0 && !v.burst && v.gap_after < 0)
            chk({nm, " cmd to result"}, res_cyc - h, v.lat + N + DRAIN + 1);
        chk({nm, " energy"}, got_e, v.e);
        chk({nm, " accept"}, got_acc, v.exp_acc);
        chk({nm, " best"}, best_energy_o, v.exp_best);
        chk({nm, " err"}, err_o, v.exp_err);
        chk({nm, " idle after"}, busy_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        int best_m;
        bit err_m, run_err, acc;

        // e, stall_idx, stall_len, gap_after, lat, burst, clr, cmd_drain, exp_acc, exp_best, exp_err
        tbl[0] = '{ -50, 0, 0, -1, 2, 0, 0, 0, 1,  -50, 0};
        tbl[1] = '{ -30, 0, 0, -1, 2, 0, 0, 0, 0,  -50, 0};
        tbl[2] = '{ -60, 2, 3, -1, 2, 1, 0, 0, 1,  -60, 0};
        tbl[3] = '{ -70, 0, 0, -1, 2, 0, 1, 1, 1, 1048575, 0};
        tbl[4] = '{ 100, 0, 0, -1, 3, 0, 0, 0, 1,  100, 0};
        tbl[5] = '{ 100, 0, 0, -1, 1, 0, 0, 0, 0,  100, 0};
        tbl[6] = '{-200, 0, 0,  1, 2, 0, 0, 0, 0,  100, 1};
        tbl[7] = '{-300, 0, 0, -1, 2, 1, 0, 0, 1, -300, 1};

        do_reset();
        for (int i = 0; i < 8; i++) do_run($sformatf("vec%0d", i), tbl[i]);

        // Randomized runs against a best-so-far model.
        do_reset();
        best_m = int'(EMAX);
        err_m  = 0;
        for (int r = 0; r < 20; r++) begin
            v.e         = int'($urandom_range(2000)) - 1000;
            v.lat       = int'($urandom_range(4, 1));
            v.stall_idx = int'($urandom_range(N - 1));
            v.stall_len = ($urandom_range(2) == 0) ? int'($urandom_range(3, 1)) : 0;
            v.burst     = (v.stall_len > 0) ? 1'b1 : 1'($urandom_range(1));
            v.gap_after = ($urandom_range(3) == 0) ? int'($urandom_range(N - 2)) : -1;
            v.clr       = ($urandom_range(5) == 0);
            v.cmd_drain = 1'($urandom_range(1));
            run_err   = (v.gap_after >= 0);
            acc       = !run_err && (v.e < best_m);
            if (v.clr)    best_m = int'(EMAX);
            else if (acc) best_m = v.e;
            if (run_err)  err_m = 1;
            v.exp_acc  = acc;
            v.exp_best = best_m;
            v.exp_err  = err_m;
            do_run($sformatf("rnd%0d", r), v);
        end

        // Reset while streaming: everything returns to idle at once and
        // late beats are not treated as a new run.
        step();
        sigma_i         = '1;
        energy_i        = -21'sd5;
        cmd_valid_i     = 1'b1;
        mem_req_ready_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            cmd_valid_i     = 1'b0;
            mem_rsp_valid_i = (i >= 3);
            @(negedge clk);
        end
        chk("midrun busy before reset", busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("midrun busy", busy_o, 0);
        chk("midrun req_valid", mem_req_valid_o, 0);
        chk("midrun best", best_energy_o, EMAX);
        chk("midrun start", mm_start_o, 0);
        step();
        @(negedge clk);
        chk("midrun err held in reset", err_o, 0);
        step();
        mem_rsp_valid_i = 1'b0;
        mem_req_ready_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post reset idle", busy_o, 0);
        chk("post reset err", err_o, 0);

        // Stray beat while idle: no start, sticky error.
        step();
        mem_rsp_valid_i = 1'b1;
        @(negedge clk);
        chk("stray beat start", mm_start_o, 0);
        step();
        mem_rsp_valid_i = 1'b0;
        @(negedge clk);
        chk("stray beat err", err_o, 1);
        chk("stray beat busy", busy_o, 0);
        repeat (3) step();
        @(negedge clk);
        chk("stray beat err sticky", err_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
